// File: rtl/hamming_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hamming_secded_decoder
// Brief    : Hamming(16,11) SECDED decoder walking encoded words in byte memory.
//            Optional error counters enabled by `define HAMMING_DEC_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_secded_decoder #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 30,
    parameter int DST_BASE = 0,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    output logic          busy
`ifdef HAMMING_DEC_ERRCNT_EN
    ,
    output logic [7:0]    err1_cnt,
    output logic [7:0]    err2_cnt
`endif
);

    localparam int            IW         = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
    localparam logic [IW-1:0] c_last_idx = IW'(NUM_MSG - 1);
    localparam logic [AW-1:0] c_src_base = AW'(SRC_BASE);
    localparam logic [AW-1:0] c_dst_base = AW'(DST_BASE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_DEC   = 3'd3,
        S_WR_HI = 3'd4,
        S_WR_LO = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [7:0]    r_lo;
    logic [7:0]    r_hi;
    logic [10:0]   r_data;
    logic [1:0]    r_flag;
    logic [7:0]    r_err1_cnt;
    logic [7:0]    r_err2_cnt;

    logic [15:0]   w_word;
    logic [15:0]   w_fixed;
    logic [3:0]    w_syn;
    logic          w_par;
    logic [1:0]    w_flag;
    logic [10:0]   w_data;

    assign w_word = {r_hi, r_lo};

    // Syndrome is the XOR of the positions of all set bits; p0 covers the whole word.
    always_comb begin
        w_syn = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (w_word[k]) begin
                w_syn = w_syn ^ 4'(k);
            end
        end
        w_par   = ^w_word;
        w_fixed = w_word;
        if (w_par) begin
            w_fixed[w_syn] = ~w_word[w_syn];
        end
        if (w_par) begin
            w_flag = 2'b01;
        end else if (w_syn != 4'd0) begin
            w_flag = 2'b10;
        end else begin
            w_flag = 2'b00;
        end
        w_data = {w_fixed[15:9], w_fixed[7:5], w_fixed[3]};
    end

    // Write data is a pure decode of registered state, so it is glitch-free and 0 at idle.
    always_comb begin
        mem_wdata = 8'h00;
        if (r_state == S_WR_HI) begin
            mem_wdata = {r_flag, 3'b000, r_data[10:8]};
        end else if (r_state == S_WR_LO) begin
            mem_wdata = r_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_lo       <= 8'h00;
            r_hi       <= 8'h00;
            r_data     <= 11'd0;
            r_flag     <= 2'b00;
            r_err1_cnt <= 8'h00;
            r_err2_cnt <= 8'h00;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_state == S_DONE) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    if (req) begin
                        r_state    <= S_RD_LO;
                        r_idx      <= '0;
                        r_src      <= c_src_base;
                        r_dst      <= c_dst_base;
                        mem_addr   <= c_src_base;
                        r_err1_cnt <= 8'h00;
                        r_err2_cnt <= 8'h00;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                S_RD_LO: begin
                    r_lo     <= mem_rdata;
                    mem_addr <= r_src + AW'(1);
                    r_state  <= S_RD_HI;
                end
                S_RD_HI: begin
                    r_hi    <= mem_rdata;
                    r_state <= S_DEC;
                end
                S_DEC: begin
                    r_data   <= w_data;
                    r_flag   <= w_flag;
                    mem_addr <= r_dst + AW'(1);
                    mem_we   <= 1'b1;
                    if (w_flag == 2'b01 && r_err1_cnt != 8'hFF) begin
                        r_err1_cnt <= r_err1_cnt + 8'd1;
                    end
                    if (w_flag == 2'b10 && r_err2_cnt != 8'hFF) begin
                        r_err2_cnt <= r_err2_cnt + 8'd1;
                    end
                    r_state <= S_WR_HI;
                end
                S_WR_HI: begin
                    mem_addr <= r_dst;
                    mem_we   <= 1'b1;
                    r_state  <= S_WR_LO;
                end
                S_WR_LO: begin
                    r_src <= r_src + AW'(2);
                    r_dst <= r_dst + AW'(2);
                    if (r_idx == c_last_idx) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx    <= r_idx + IW'(1);
                        mem_addr <= r_src + AW'(2);
                        r_state  <= S_RD_LO;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HAMMING_DEC_ERRCNT_EN
    assign err1_cnt = r_err1_cnt;
    assign err2_cnt = r_err2_cnt;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^{r_err1_cnt, r_err2_cnt};
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_secded_decoder
// Brief    : Directed self-checking bench for hamming_secded_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_secded_decoder;

    localparam int NUM_MSG = 15;
    localparam int SRC     = 30;
    localparam int DST     = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       busy;
`ifdef HAMMING_DEC_ERRCNT_EN
    logic [7:0] err1_cnt;
    logic [7:0] err2_cnt;
`endif

    logic [7:0]  src_mem [0:255];
    logic [7:0]  dst_mem [0:255];
    logic [15:0] exp_out [0:NUM_MSG-1];
    int          n_wr = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_e1;
    int          exp_e2;

    always #5 clk = ~clk;

    assign mem_rdata = src_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            dst_mem[mem_addr] <= mem_wdata;
            n_wr <= n_wr + 1;
        end
    end

    hamming_secded_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy)
`ifdef HAMMING_DEC_ERRCNT_EN
        ,
        .err1_cnt  (err1_cnt),
        .err2_cnt  (err2_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoder: data into non-power-of-two slots, then each parity bit.
    function automatic logic [15:0] enc(input logic [10:0] m);
        logic [15:0] cw;
        logic        b;
        int          pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        cw = 16'h0000;
        for (int j = 0; j < 11; j++) cw[pos[j]] = m[j];
        for (int p = 1; p < 16; p = p * 2) begin
            b = 1'b0;
            for (int k = 1; k < 16; k++) begin
                if ((k & p) != 0 && k != p) b = b ^ cw[k];
            end
            cw[p] = b;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    task automatic set_word(input int i, input logic [15:0] w, input logic [15:0] e);
        src_mem[SRC + 2*i]     = w[7:0];
        src_mem[SRC + 2*i + 1] = w[15:8];
        exp_out[i]             = e;
    endtask

    task automatic gen_slot(input int i, input int nflip);
        logic [10:0] m;
        logic [15:0] w;
        int          a;
        int          b;
        m = 11'($urandom_range(0, 2047));
        w = enc(m);
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        if (nflip == 0) begin
            set_word(i, w, {2'b00, 3'b000, m});
        end else if (nflip == 1) begin
            w[a] = ~w[a];
            set_word(i, w, {2'b01, 3'b000, m});
            exp_e1++;
        end else begin
            w[a] = ~w[a];
            w[b] = ~w[b];
            set_word(i, w, {2'b10, 3'b000, w[15:9], w[7:5], w[3]});
            exp_e2++;
        end
    endtask

    task automatic run_req(input int mid, input string tag);
        int lat;
        int w0;
        bit seen;
        w0   = n_wr;
        seen = 1'b0;
        lat  = 0;
        @(negedge clk) req = 1'b1;
        @(posedge clk);
        #1 chk({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk) req = 1'b0;
        while (lat < 200 && !seen) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) seen = 1'b1;
            req = (lat == mid) ? 1'b1 : 1'b0;
        end
        req = 1'b0;
        if (!seen) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'd76);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_writes"}, 32'(n_wr - w0), 32'd30);
        for (int i = 0; i < NUM_MSG; i++) begin
            chk($sformatf("%s_out%0d", tag, i),
                32'({dst_mem[DST + 2*i + 1], dst_mem[DST + 2*i]}), 32'(exp_out[i]));
        end
`ifdef HAMMING_DEC_ERRCNT_EN
        chk({tag, "_err1"}, 32'(err1_cnt), 32'(exp_e1));
        chk({tag, "_err2"}, 32'(err2_cnt), 32'(exp_e2));
`endif
    endtask

    initial begin
        int w0;
        reset = 1'b1;
        req   = 1'b0;
        for (int a = 0; a < 256; a++) src_mem[a] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk) reset = 1'b0;

        // All-ones words are valid codewords carrying all-ones data.
        exp_e1 = 0;
        exp_e2 = 0;
        for (int i = 0; i < NUM_MSG; i++) set_word(i, 16'hFFFF, 16'h07FF);
        run_req(-1, "ones");

        // Hand-computed error cases followed by random 0/1/2-flip slots.
        exp_e1 = 2;
        exp_e2 = 1;
        set_word(0, 16'h0020, 16'h4000);
        set_word(1, 16'h0001, 16'h4000);
        set_word(2, 16'h0028, 16'h8003);
        for (int i = 3; i < NUM_MSG; i++) gen_slot(i, i % 3);
        run_req(-1, "mix");

        // Reset during message 7 RD_HI, then a clean run with a stray req mid-run.
        exp_e1 = 0;
        exp_e2 = 0;
        for (int i = 0; i < NUM_MSG; i++) gen_slot(i, $urandom_range(0, 2));
        w0 = n_wr;
        @(negedge clk) req = 1'b1;
        @(posedge clk);
        @(negedge clk) req = 1'b0;
        repeat (36) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_writes", 32'(n_wr - w0), 32'd14);
        @(negedge clk) reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_writes", 32'(n_wr - w0), 32'd14);
        chk("post_rst_done", 32'(done), 32'd0);
        run_req(20, "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Program-2 companion to the Hamming(16,11) SECDED encoder: the receive-side decoder.
- On a `req` pulse it walks 15 encoded 16-bit words in byte-wide data memory.
- For each word it computes the syndrome and overall parity, corrects any single-bit error and flags double-bit errors.
- It writes each 11-bit message back with 2-bit status flags, then raises `done`. It shares the data-memory port with the core and owns it only while busy.

Parameters:
- NUM_MSG, 15: number of messages per run.
- SRC_BASE, 30: byte address of the first encoded word (LSB byte; MSB byte at +1).
- DST_BASE, 0: byte address of the first decoded output (LSB byte; MSB byte at +1).
- AW, 8: data-memory address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start pulse, sampled only in IDLE or DONE.
- done  out  1  high when a run completes; held until the next accepted `req` or `reset`.
- mem_addr  out  AW  data-memory byte address.
- mem_rdata  in  8  data-memory read data, combinational (valid in the same cycle as `mem_addr`).
- mem_wdata  out  8  data-memory write data.
- mem_we  out  1  write enable; the write lands at the clk edge.
- busy  out  1  high from the cycle after `req` is accepted until `done`.

Behaviour:
- Reset values: done=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0. State=IDLE, msg index i=0.
- Encoded word layout, index:bit: 15..9=d11..d5, 8=p8, 7..5=d4..d2, 4=p4, 3=d1, 2=p2, 1=p1, 0=p0.
- Word assembly: word = {mem[SRC_BASE+2i+1], mem[SRC_BASE+2i]}.
- Syndrome s[3:0] = XOR of indices k (1..15) where word[k]=1. Overall parity P = XOR of all 16 bits.
- s=0, P=0: no error, F=2'b00.
- P=1: single error at bit s; s=0 means p0 itself flipped. Flip word[s], F=2'b01.
- s!=0, P=0: double error, F=2'b10. Data is extracted uncorrected.
- Output MSB byte = {F[1:0], 3'b000, d11, d10, d9}. Output LSB byte = d8..d1.
- Output MSB goes to DST_BASE+2i+1; output LSB goes to DST_BASE+2i.
- FSM: IDLE -> RD_LO -> RD_HI -> DEC -> WR_HI -> WR_LO -> (i==NUM_MSG-1 ? DONE : RD_LO, with i++).
- IDLE: on req=1, go to RD_LO, i=0, busy=1, done=0.
- RD_LO / RD_HI: drive the address and latch `mem_rdata` into the low/high word register at the clock edge.
- DEC: register s, P, corrected data and F. No memory access, mem_we=0.
- WR_HI / WR_LO: mem_we=1 for exactly one cycle each, with address and data as above.
- DONE: done=1, busy=0. On req=1, restart exactly as from IDLE (done drops the next cycle).
- Latency: 5 cycles per message. `done` rises 5*NUM_MSG+1 cycles after the req-accept edge (76 for the default).
- `req` while busy: ignored, the run is not restarted.
- `reset` mid-run: return to IDLE next edge with mem_we=0. Partially written outputs stay in memory; no further writes occur.
- Address arithmetic wraps modulo 2^AW. The source and destination regions must not overlap; this is not checked.
- mem_we is never high outside WR_HI/WR_LO.

Optional Feature:
- Macro: HAMMING_DEC_ERRCNT_EN.
- Defined: adds output ports err1_cnt[7:0] and err2_cnt[7:0].
  - They count single-corrected and double-detected messages in the current run.
  - Both clear to 0 on `reset` and on `req` acceptance, increment in DEC, and saturate at 255.
  - Both hold their values in DONE.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- All 15 source words = 0xFFFF, then a req pulse: every output pair is MSB=0x07, LSB=0xFF. `done` is seen exactly 76 cycles after the accepting edge. errcnts are 0/0 when the feature is enabled.
- Word 0x0020 (d2 flipped in the all-zero codeword): output MSB=0x40, LSB=0x00. err1_cnt increments.
- Word 0x0001 (p0 flipped): output MSB=0x40, LSB=0x00.
- Word 0x0028 (d1 and d2 flipped, s=6, P=0): output MSB=0x80, LSB=0x03 (uncorrected). err2_cnt increments.
- Random 11-bit messages, encoded with 0, 1 or 2 random bit flips, across all 15 slots: outputs match the reference model. mem_we is asserted exactly 30 times per run.
- Assert reset during message 7's RD_HI: the FSM is in IDLE the next cycle with done=0, busy=0, mem_we=0 and no later writes. A subsequent req completes normally. A req pulsed mid-run leaves the cycle count unchanged.
